data_mem_responder: RTL

//   Data-memory responder on the far end of the CPU's M-stage memory port.

---
 rtl/data_mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word reads, byte-enabled synchronous writes,
// a one-cycle write-trace record per committed write, and sticky out-of-range error capture.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  input  logic [3:0]  byte_en,
  input  logic [31:0] pc_m,
  output logic [31:0] mem_rd,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] write_count,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [IDX_W-1:0] idx;
  logic        in_range;
  logic        wr_req;
  logic        wr_en;
  logic [31:0] old_word;
  logic [31:0] mask;
  logic [31:0] merged;

  logic        trace_valid_d, trace_valid_q;
  logic [31:0] trace_pc_d,    trace_pc_q;
  logic [31:0] trace_addr_d,  trace_addr_q;
  logic [31:0] trace_data_d,  trace_data_q;
  logic [31:0] write_count_d, write_count_q;
  logic        addr_err_d,    addr_err_q;
  logic [31:0] err_addr_d,    err_addr_q;

  // Address decode and byte-lane merge against the current (pre-edge) word.
  always_comb begin
    offset   = mem_addr - BASE_ADDR;
    word_idx = offset[31:2];
    idx      = offset[IDX_W+1:2];
    in_range = (mem_addr >= BASE_ADDR) && (word_idx < 30'(DEPTH_WORDS));
    wr_req   = (byte_en != 4'b0000);
    wr_en    = wr_req && in_range;
    old_word = in_range ? mem_q[idx] : 32'h0;
    mask     = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{byte_en[i]}};
    end
    merged   = (old_word & ~mask) | (mem_wd & mask);
  end

  assign mem_rd = old_word;

  // Next-state for trace, counter and error capture.
  always_comb begin
    trace_valid_d = wr_en;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    write_count_d = write_count_q;
    addr_err_d    = addr_err_q;
    err_addr_d    = err_addr_q;
    if (wr_en) begin
      trace_pc_d    = pc_m;
      trace_addr_d  = {mem_addr[31:2], 2'b00};
      trace_data_d  = merged;
      write_count_d = write_count_q + 32'd1;
    end
    if (wr_req && !in_range) begin
      addr_err_d = 1'b1;
      if (!addr_err_q) err_addr_d = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      write_count_q <= '0;
      addr_err_q    <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
      write_count_q <= write_count_d;
      addr_err_q    <= addr_err_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign write_count = write_count_q;
  assign addr_err    = addr_err_q;
  assign err_addr    = err_addr_q;

endmodule
